// File: rtl/dm_subword_mem_pkg.sv
// dm_subword_mem_pkg: opcodes, FSM states and access sizes shared by the data-memory stage.
package dm_subword_mem_pkg;
   localparam int DMEM_SIZE = 1024;
   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
   localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, JAL = 6'h03;
   localparam logic [5:0] JALR = 6'h09;
   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
endpackage

// File: rtl/dm_subword_mem_lane.sv
// dm_lane: big-endian byte/halfword extraction, store merge and misalignment detection.
module dm_lane
   import dm_subword_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  size_t       size,
   input  logic        sign,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] merged,
   output logic        misalign
);
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] bmask, hmask, bdat, hdat;
   always_comb begin
      b        = 8'(word >> {~lane, 3'b000});
      h        = 16'(word >> {~lane[1], 4'b0000});
      bmask    = 32'hFF00_0000 >> {lane, 3'b000};
      hmask    = 32'hFFFF_0000 >> {lane[1], 4'b0000};
      bdat     = {wdata[7:0], 24'h0} >> {lane, 3'b000};
      hdat     = {wdata[15:0], 16'h0} >> {lane[1], 4'b0000};
      rdata    = size == SZ_B ? {{24{sign & b[7]}}, b} :
                 size == SZ_H ? {{16{sign & h[15]}}, h} : word;
      merged   = size == SZ_B ? (word & ~bmask) | bdat :
                 size == SZ_H ? (word & ~hmask) | hdat : wdata;
      misalign = (size == SZ_H && lane[0]) || (size == SZ_W && lane != 2'b00);
   end
endmodule

// File: rtl/dm_subword_mem.sv
// dm_subword_mem: data memory with sub-word access, load latency stall, post-reset clear
// and register-file writeback select.
module dm_subword_mem
   import dm_subword_mem_pkg::*;
#(
   parameter int DEPTH          = DMEM_SIZE,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int LOAD_LATENCY   = 0,
   parameter bit CLEAR_ON_RESET = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Result,
   input  logic [31:0] Rdata2,
   input  logic [31:0] nextPC,
   input  logic [31:0] Ins,
   output logic [31:0] Wdata,
   output logic        Stall,
   output logic        AdrErr
);
   localparam int LAT_W = LOAD_LATENCY > 2 ? $clog2(LOAD_LATENCY) : 1;
   localparam state_t RST_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   logic [31:0]       mem [DEPTH];
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_q, clr_d, widx, waddr;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [31:0]       ld_q, ld_d, rd_word, ld_data, merged, wval;
   logic [5:0]        op;
   logic              is_load, is_store, sign, link, misalign, we;
   size_t             size;
   logic              unused_bits;

   assign op          = Ins[31:26];
   assign widx        = Result[ADDR_W+1:2];
   assign rd_word     = mem[widx];
   assign unused_bits = ^{Result[31:ADDR_W+2], Ins[25:6]};

   always_comb begin
      is_load  = op inside {LB, LH, LW, LBU, LHU};
      is_store = op inside {SB, SH, SW};
      size     = (op == LB || op == LBU || op == SB) ? SZ_B :
                 (op == LH || op == LHU || op == SH) ? SZ_H : SZ_W;
      sign     = op == LB || op == LH;
      link     = op == JAL || (op == 6'h00 && Ins[5:0] == JALR);
   end

   dm_lane u_lane (
      .word     (rd_word),
      .lane     (Result[1:0]),
      .size     (size),
      .sign     (sign),
      .wdata    (Rdata2),
      .rdata    (ld_data),
      .merged   (merged),
      .misalign (misalign)
   );

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      lat_d   = lat_q;
      ld_d    = ld_q;
      we      = 1'b0;
      waddr   = widx;
      wval    = merged;
      Stall   = 1'b0;
      AdrErr  = 1'b0;
      Wdata   = Result;
      case (state_q)
         ST_CLEAR: begin
            we      = 1'b1;
            waddr   = clr_q;
            wval    = '0;
            Stall   = 1'b1;
            Wdata   = '0;
            clr_d   = clr_q + 1'b1;
            state_d = clr_q == ADDR_W'(DEPTH - 1) ? ST_IDLE : ST_CLEAR;
         end
         ST_IDLE: begin
            AdrErr = (is_load || is_store) && misalign;
            we     = is_store && !misalign;
            Wdata  = is_load ? (misalign ? 32'h0 : ld_data) : link ? nextPC : Result;
            if (LOAD_LATENCY > 0 && is_load && !misalign) begin
               Stall   = 1'b1;
               lat_d   = '0;
               ld_d    = ld_data;
               state_d = LOAD_LATENCY == 1 ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            Stall = 1'b1;
            Wdata = ld_q;
            lat_d = lat_q + 1'b1;
            if (int'(lat_q) == LOAD_LATENCY - 2) begin
               ld_d    = ld_data;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            Wdata   = ld_q;
            state_d = ST_IDLE;
         end
         default: state_d = RST_ST;
      endcase
      // an edge arriving while reset is held must never commit a write
      if (!RST) begin
         we     = 1'b0;
         Stall  = CLEAR_ON_RESET;
         AdrErr = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= RST_ST;
         clr_q   <= '0;
         lat_q   <= '0;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         lat_q   <= lat_d;
         ld_q    <= ld_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wval;
   end
endmodule

// File: tb/tb_dm_subword_mem.sv
// tb_dm_subword_mem: directed checks of clear, sub-word access, misalignment, writeback
// select, load latency and reset abort on two configurations.
module tb_dm_subword_mem;
   import dm_subword_mem_pkg::*;

   logic        CLK, RST;
   logic [31:0] Result, Rdata2, nextPC, Ins;
   logic [31:0] w0, w1;
   logic        s0, s1, e0, e1;
   int          total = 0, bad = 0;

   dm_subword_mem #(.DEPTH(16), .LOAD_LATENCY(0), .CLEAR_ON_RESET(1)) u0 (
      .CLK(CLK), .RST(RST), .Result(Result), .Rdata2(Rdata2), .nextPC(nextPC), .Ins(Ins),
      .Wdata(w0), .Stall(s0), .AdrErr(e0)
   );

   dm_subword_mem #(.DEPTH(1024), .LOAD_LATENCY(2), .CLEAR_ON_RESET(1)) u1 (
      .CLK(CLK), .RST(RST), .Result(Result), .Rdata2(Rdata2), .nextPC(nextPC), .Ins(Ins),
      .Wdata(w1), .Stall(s1), .AdrErr(e1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] res;
      logic [31:0] d2;
      logic [31:0] npc;
      logic [31:0] w;
      logic        cw;
      logic        e;
   } vec_t;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] res,
                        input logic [31:0] d2, input logic [31:0] npc);
      Ins    = {op, 20'h0, fn};
      Result = res;
      Rdata2 = d2;
      nextPC = npc;
      #1;
   endtask

   task automatic test_reset();
      int n;
      RST = 1'b0;
      drive(6'h00, 6'h20, 32'h0, 32'h0, 32'h0);
      #2;
      total += 3;
      if (s0 !== 1'b1) begin bad++; $display("FAIL rst_stall0 got %b exp 1", s0); end
      if (e0 !== 1'b0) begin bad++; $display("FAIL rst_adrerr0 got %b exp 0", e0); end
      if (s1 !== 1'b1) begin bad++; $display("FAIL rst_stall1 got %b exp 1", s1); end
      step();
      RST = 1'b1;
      #1;
      n = 0;
      while (s0 === 1'b1 && n < 40) begin
         if (n == 3) begin
            total++;
            if (w0 !== 32'h0) begin bad++; $display("FAIL clear_wdata got %h exp 0", w0); end
         end
         n++;
         step();
      end
      total++;
      if (n != 16) begin bad++; $display("FAIL clear_len got %0d exp 16", n); end
      drive(LW, 6'h0, 32'h3C, 32'h0, 32'h0);
      total += 2;
      if (w0 !== 32'h0) begin bad++; $display("FAIL cleared_lw got %h exp 0", w0); end
      if (s0 !== 1'b0) begin bad++; $display("FAIL cleared_stall got %b exp 0", s0); end
      step();
   endtask

   task automatic test_subword();
      vec_t v[17];
      v = '{
         '{SW,    6'h00, 32'h40, 32'h11223344, 32'h0,   32'h0,        1'b0, 1'b0},
         '{LW,    6'h00, 32'h40, 32'h0,        32'h0,   32'h11223344, 1'b1, 1'b0},
         '{LB,    6'h00, 32'h41, 32'h0,        32'h0,   32'h00000022, 1'b1, 1'b0},
         '{LH,    6'h00, 32'h42, 32'h0,        32'h0,   32'h00003344, 1'b1, 1'b0},
         '{SB,    6'h00, 32'h43, 32'h123456AA, 32'h0,   32'h0,        1'b0, 1'b0},
         '{LW,    6'h00, 32'h40, 32'h0,        32'h0,   32'h112233AA, 1'b1, 1'b0},
         '{SH,    6'h00, 32'h10, 32'hABCD8001, 32'h0,   32'h0,        1'b0, 1'b0},
         '{LH,    6'h00, 32'h10, 32'h0,        32'h0,   32'hFFFF8001, 1'b1, 1'b0},
         '{LHU,   6'h00, 32'h10, 32'h0,        32'h0,   32'h00008001, 1'b1, 1'b0},
         '{LB,    6'h00, 32'h10, 32'h0,        32'h0,   32'hFFFFFF80, 1'b1, 1'b0},
         '{LBU,   6'h00, 32'h11, 32'h0,        32'h0,   32'h00000001, 1'b1, 1'b0},
         '{LW,    6'h00, 32'h06, 32'h0,        32'h0,   32'h0,        1'b1, 1'b1},
         '{SH,    6'h00, 32'h05, 32'hFFFFFFFF, 32'h0,   32'h0,        1'b0, 1'b1},
         '{LW,    6'h00, 32'h04, 32'h0,        32'h0,   32'h0,        1'b1, 1'b0},
         '{JAL,   6'h00, 32'h55, 32'h0,        32'h104, 32'h104,      1'b1, 1'b0},
         '{6'h00, JALR,  32'h66, 32'h0,        32'h200, 32'h200,      1'b1, 1'b0},
         '{6'h00, 6'h20, 32'h07, 32'h0,        32'h300, 32'h7,        1'b1, 1'b0}
      };
      for (int i = 0; i < 17; i++) begin
         drive(v[i].op, v[i].fn, v[i].res, v[i].d2, v[i].npc);
         total += 2;
         if (e0 !== v[i].e) begin bad++; $display("FAIL sub_adrerr[%0d] got %b exp %b", i, e0, v[i].e); end
         if (s0 !== 1'b0) begin bad++; $display("FAIL sub_stall[%0d] got %b exp 0", i, s0); end
         if (v[i].cw) begin
            total++;
            if (w0 !== v[i].w) begin bad++; $display("FAIL sub_wdata[%0d] got %h exp %h", i, w0, v[i].w); end
         end
         step();
      end
   endtask

   task automatic test_latency();
      int n;
      drive(6'h00, 6'h20, 32'h0, 32'h0, 32'h0);
      n = 0;
      while (s1 === 1'b1 && n < 1100) begin n++; step(); end
      total++;
      if (s1 !== 1'b0) begin bad++; $display("FAIL wait_clear1 got stall %b exp 0", s1); end
      drive(SW, 6'h0, 32'h40, 32'h5, 32'h0);
      step();
      drive(LW, 6'h0, 32'h40, 32'h0, 32'h0);
      total += 2;
      if (s1 !== 1'b1) begin bad++; $display("FAIL lat_stall_c0 got %b exp 1", s1); end
      if (e1 !== 1'b0) begin bad++; $display("FAIL lat_adrerr got %b exp 0", e1); end
      step();
      total++;
      if (s1 !== 1'b1) begin bad++; $display("FAIL lat_stall_c1 got %b exp 1", s1); end
      step();
      total += 2;
      if (s1 !== 1'b0) begin bad++; $display("FAIL lat_stall_c2 got %b exp 0", s1); end
      if (w1 !== 32'h5) begin bad++; $display("FAIL lat_wdata got %h exp 5", w1); end
      step();
      drive(SW, 6'h0, 32'h1004, 32'hCAFEF00D, 32'h0);
      step();
      drive(LW, 6'h0, 32'h4, 32'h0, 32'h0);
      step();
      step();
      total += 2;
      if (s1 !== 1'b0) begin bad++; $display("FAIL wrap_stall got %b exp 0", s1); end
      if (w1 !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_wdata got %h exp cafef00d", w1); end
      step();
      drive(LW, 6'h0, 32'h42, 32'h0, 32'h0);
      total += 3;
      if (s1 !== 1'b0) begin bad++; $display("FAIL mis_lat_stall got %b exp 0", s1); end
      if (e1 !== 1'b1) begin bad++; $display("FAIL mis_lat_adrerr got %b exp 1", e1); end
      if (w1 !== 32'h0) begin bad++; $display("FAIL mis_lat_wdata got %h exp 0", w1); end
      step();
   endtask

   task automatic test_reset_mid_wait();
      int n0, n1;
      drive(LW, 6'h0, 32'h40, 32'h0, 32'h0);
      step();
      total++;
      if (s1 !== 1'b1) begin bad++; $display("FAIL mid_wait_stall got %b exp 1", s1); end
      #2;
      RST = 1'b0;
      #1;
      total += 3;
      if (s1 !== 1'b1) begin bad++; $display("FAIL mid_rst_stall1 got %b exp 1", s1); end
      if (s0 !== 1'b1) begin bad++; $display("FAIL mid_rst_stall0 got %b exp 1", s0); end
      if (e1 !== 1'b0) begin bad++; $display("FAIL mid_rst_adrerr got %b exp 0", e1); end
      step();
      drive(6'h00, 6'h20, 32'h0, 32'h0, 32'h0);
      step();
      RST = 1'b1;
      #1;
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 1100 && (s0 === 1'b1 || s1 === 1'b1); i++) begin
         n0 += int'(s0);
         n1 += int'(s1);
         step();
      end
      total += 2;
      if (n0 != 16) begin bad++; $display("FAIL reclear_len0 got %0d exp 16", n0); end
      if (n1 != 1024) begin bad++; $display("FAIL reclear_len1 got %0d exp 1024", n1); end
      drive(LW, 6'h0, 32'h40, 32'h0, 32'h0);
      total += 2;
      if (w0 !== 32'h0) begin bad++; $display("FAIL reclear_lw0 got %h exp 0", w0); end
      if (s1 !== 1'b1) begin bad++; $display("FAIL reclear_stall1 got %b exp 1", s1); end
      step();
      step();
      total++;
      if (w1 !== 32'h0) begin bad++; $display("FAIL reclear_lw1 got %h exp 0", w1); end
      step();
   endtask

   initial begin
      test_reset();
      test_subword();
      test_latency();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dm_subword_mem.md
Name: dm_subword_mem

Overview:
- Parametrised successor to the single-cycle data-memory/writeback stage.
- Adds byte and halfword loads and stores, misalignment detection, configurable load latency with a core stall, and a sequential memory clear after reset.
- Sits between the ALU result and the register-file write port; it also performs the writeback select (load data / link address / ALU result).

Parameters:
- DEPTH, 1024: words of data memory; must be a power of two.
- ADDR_W, $clog2(DEPTH): word-index width; derived, not overridden.
- LOAD_LATENCY, 0: cycles from load issue to data valid; 0 gives a combinational read.
- CLEAR_ON_RESET, 1: 1 zeroes the memory sequentially after reset; 0 skips the clear.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- Result  in  32  ALU result, used as byte address
- Rdata2  in  32  store data
- nextPC  in  32  PC+4, used as the link value
- Ins  in  32  current instruction
- Wdata  out  32  register writeback value
- Stall  out  1  core must hold Ins, Result, Rdata2 and nextPC stable and not commit
- AdrErr  out  1  misaligned access on the current instruction

Behaviour:
- Addressing:
  - word index = Result[ADDR_W+1:2], wrapping modulo DEPTH.
  - byte lane = Result[1:0], big-endian: lane 0 = bits [31:24].
- Opcodes:
  - LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B, JAL 0x03.
  - JALR is opcode 0 with funct 0x09.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - SB/SH merge only the addressed lanes (Rdata2[7:0] or Rdata2[15:0]); SW writes the full word.
  - Written at the rising edge ending the cycle, only in IDLE.
  - Stores never stall.
- Misalignment:
  - halfword access with Result[0]=1, or word access with Result[1:0]≠0.
  - AdrErr=1 combinationally; store suppressed; load returns Wdata=0 and does not stall.
- Writeback select:
  - loads → extracted data.
  - JAL, or opcode 0 with funct JALR → nextPC.
  - otherwise → Result.
- FSM states: CLEAR, IDLE, WAIT, DONE.
- Reset asserted (async):
  - state = CLEAR if CLEAR_ON_RESET else IDLE; clear counter = 0; latency counter = 0; load register = 0.
  - Stall = CLEAR_ON_RESET; AdrErr = 0.
- CLEAR:
  - one word zeroed per cycle, index 0..DEPTH-1.
  - Stall=1, Wdata=0, AdrErr=0; instructions ignored, no stores.
  - After writing DEPTH-1 → IDLE. Duration is exactly DEPTH cycles after reset release.
- IDLE:
  - LOAD_LATENCY=0: loads read combinationally, Stall=0.
  - LOAD_LATENCY=L≥1, aligned load seen in cycle t:
    - Stall=1 in cycles t..t+L-1 (state WAIT from t+1); data latched at the edge ending t+L-1.
    - DONE in cycle t+L: Stall=0, Wdata = latched value, then → IDLE.
    - DONE prevents re-issuing the same load.
- Read-after-write: store in cycle t, load of the same word in t+1 returns the merged data.
- Reset mid-WAIT/DONE/CLEAR: abort immediately; restart per reset rules; no partial write.
- Outputs in WAIT/DONE are driven only from registered state; Ins changes during Stall are a core protocol violation and undefined.

Decomposition:
- Shared header common_param.vh holds:
  - opcode constants LB, LH, LW, LBU, LHU, SB, SH, SW, JAL;
  - funct constant JALR;
  - the DMEM_SIZE default;
  - FSM state encodings ST_CLEAR, ST_IDLE, ST_WAIT, ST_DONE.
- Sub-module dm_lane (combinational):
  - load extract/extend: word, lane, size, sign → 32b.
  - store merge: old word, Rdata2, lane, size → new word.
  - misalignment flag.
- Top holds the memory array, FSM, counters and writeback mux.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH=16 → Stall=1 for exactly 16 cycles, then 0; LW at any address returns 0.
- SW 0x11223344 @0x40; then LB @0x41 → 0x00000022; LH @0x42 → 0x00003344; SB 0xAA @0x43 then LW → 0x112233AA.
- SH 0x8001 @0x10; LH → 0xFFFF8001; LHU → 0x00008001; LB @0x10 → 0xFFFFFF80.
- LW @0x06 → AdrErr=1, Wdata=0, no stall; SH @0x05 → AdrErr=1 and memory word unchanged.
- LOAD_LATENCY=2, LW @0x40 holding 0x5 → Stall high 2 cycles, 0 in the 3rd with Wdata=0x5; RST low during the 1st stall cycle → CLEAR restarts, no write.
- JAL with nextPC=0x104 → Wdata=0x104; opcode 0 funct 0x09 → nextPC; ADD with Result=0x7 → Wdata=0x7; address 0x1004 with DEPTH=1024 wraps to word 1.
